// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file, immediate extension, destination select,
// load-use stall and a registered ID/EX output. Define WB_BYPASS_EN for same-cycle WB forwarding.
module decode_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           if_instr_i,
  input  logic [31:0]           if_pc_i,
  input  logic                  if_valid_i,
  output logic                  if_ready_o,
  input  logic                  flush_i,
  input  logic                  wb_en_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  ex_ready_i,
  output logic                  out_valid_o,
  output logic [31:0]           out_pc_o,
  output logic [DATA_WIDTH-1:0] out_rs_data_o,
  output logic [DATA_WIDTH-1:0] out_rt_data_o,
  output logic [DATA_WIDTH-1:0] out_imm_o,
  output logic [REG_ADDR_W-1:0] out_rs_o,
  output logic [REG_ADDR_W-1:0] out_rt_o,
  output logic [REG_ADDR_W-1:0] out_dest_o,
  output logic [5:0]            out_opcode_o,
  output logic [5:0]            out_funct_o,
  output logic [4:0]            out_shamt_o,
  output logic                  out_is_load_o
);

  logic [5:0]            opcode, funct;
  logic [4:0]            shamt;
  logic [15:0]           imm16;
  logic [REG_ADDR_W-1:0] rs_idx, rt_idx, rd_idx, dest;
  logic [DATA_WIDTH-1:0] imm_ext, rs_data, rt_data;
  logic                  is_load, wr_en, adv, hazard, load_en, valid_d;

  logic [DATA_WIDTH-1:0] rf_q [REG_COUNT];

  logic                  valid_q, is_load_q;
  logic [31:0]           pc_q;
  logic [DATA_WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, dest_q;
  logic [5:0]            opcode_q, funct_q;
  logic [4:0]            shamt_q;

  assign opcode  = if_instr_i[31:26];
  assign rs_idx  = REG_ADDR_W'(if_instr_i[25:21]);
  assign rt_idx  = REG_ADDR_W'(if_instr_i[20:16]);
  assign rd_idx  = REG_ADDR_W'(if_instr_i[15:11]);
  assign shamt   = if_instr_i[10:6];
  assign funct   = if_instr_i[5:0];
  assign imm16   = if_instr_i[15:0];
  assign is_load = (opcode[5:3] == 3'b100);

  assign wr_en = wb_en_i && (wb_addr_i != '0) && (32'(wb_addr_i) < REG_COUNT);

  always_comb begin
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_WIDTH'(imm16);
      6'h0F:               imm_ext = DATA_WIDTH'({imm16, 16'h0000});
      default:             imm_ext = DATA_WIDTH'($signed(imm16));
    endcase
  end

  always_comb begin
    if (opcode == 6'h00) begin
      dest = rd_idx;
    end else if (opcode == 6'h03) begin
      dest = REG_ADDR_W'(5'd31);
    end else begin
      dest = rt_idx;
    end
  end

  // Entry 0 is never written, and out-of-range indices read as zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_idx != '0 && 32'(rs_idx) < REG_COUNT) rs_data = rf_q[rs_idx];
    if (rt_idx != '0 && 32'(rt_idx) < REG_COUNT) rt_data = rf_q[rt_idx];
`ifdef WB_BYPASS_EN
    if (wr_en && wb_addr_i == rs_idx) rs_data = wb_data_i;
    if (wr_en && wb_addr_i == rt_idx) rt_data = wb_data_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  assign adv    = !valid_q || ex_ready_i;
  assign hazard = valid_q && is_load_q && (dest_q != '0) &&
                  ((dest_q == rs_idx) || (dest_q == rt_idx));
  assign if_ready_o = rst_ni && adv && !hazard;

  // Flush beats the stall; a stall under backpressure keeps the held instruction.
  always_comb begin
    valid_d = valid_q;
    load_en = 1'b0;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (adv) begin
      if (hazard) begin
        valid_d = 1'b0;
      end else if (if_valid_i) begin
        valid_d = 1'b1;
        load_en = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
      opcode_q  <= '0;
      funct_q   <= '0;
      shamt_q   <= '0;
      is_load_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (load_en) begin
        pc_q      <= if_pc_i;
        rs_data_q <= rs_data;
        rt_data_q <= rt_data;
        imm_q     <= imm_ext;
        rs_q      <= rs_idx;
        rt_q      <= rt_idx;
        dest_q    <= dest;
        opcode_q  <= opcode;
        funct_q   <= funct;
        shamt_q   <= shamt;
        is_load_q <= is_load;
      end
    end
  end

  assign out_valid_o   = valid_q;
  assign out_pc_o      = pc_q;
  assign out_rs_data_o = rs_data_q;
  assign out_rt_data_o = rt_data_q;
  assign out_imm_o     = imm_q;
  assign out_rs_o      = rs_q;
  assign out_rt_o      = rt_q;
  assign out_dest_o    = dest_q;
  assign out_opcode_o  = opcode_q;
  assign out_funct_o   = funct_q;
  assign out_shamt_o   = shamt_q;
  assign out_is_load_o = is_load_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed literal checks followed by randomized traffic against
// a behavioural model of the ID/EX register and register file.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc;
  logic        ivalid, flush, wb_en, ex_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        if_ready, out_valid, out_is_load;
  logic [31:0] out_pc, out_rs_data, out_rt_data, out_imm;
  logic [4:0]  out_rs, out_rt, out_dest, out_shamt;
  logic [5:0]  out_opcode, out_funct;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int unsigned m_regs [32];
  bit          m_valid, m_load;
  int unsigned m_pc, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_dest, m_op, m_funct, m_shamt;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .if_instr_i    (instr),
    .if_pc_i       (pc),
    .if_valid_i    (ivalid),
    .if_ready_o    (if_ready),
    .flush_i       (flush),
    .wb_en_i       (wb_en),
    .wb_addr_i     (wb_addr),
    .wb_data_i     (wb_data),
    .ex_ready_i    (ex_ready),
    .out_valid_o   (out_valid),
    .out_pc_o      (out_pc),
    .out_rs_data_o (out_rs_data),
    .out_rt_data_o (out_rt_data),
    .out_imm_o     (out_imm),
    .out_rs_o      (out_rs),
    .out_rt_o      (out_rt),
    .out_dest_o    (out_dest),
    .out_opcode_o  (out_opcode),
    .out_funct_o   (out_funct),
    .out_shamt_o   (out_shamt),
    .out_is_load_o (out_is_load)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  function automatic int unsigned rd_val(int unsigned idx);
    if (idx == 0) return 0;
`ifdef WB_BYPASS_EN
    if (wb_en && 32'(wb_addr) == idx) return wb_data;
`endif
    return m_regs[idx];
  endfunction

  function automatic bit hazard_f();
    int unsigned rs = (instr >> 21) % 32;
    int unsigned rt = (instr >> 16) % 32;
    return m_valid && m_load && m_dest != 0 && (m_dest == rs || m_dest == rt);
  endfunction

  function automatic bit exp_ready_f();
    return rst_n && (!m_valid || ex_ready) && !hazard_f();
  endfunction

  task automatic model_step();
    int unsigned op, rs, rt, rd, im;
    bit adv, haz;
    op  = instr >> 26;
    rs  = (instr >> 21) % 32;
    rt  = (instr >> 16) % 32;
    rd  = (instr >> 11) % 32;
    im  = instr % 65536;
    adv = !m_valid || ex_ready;
    haz = hazard_f();
    if (!rst_n) begin
      m_valid = 0; m_load = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_dest = 0; m_op = 0; m_funct = 0; m_shamt = 0;
      foreach (m_regs[i]) m_regs[i] = 0;
      return;
    end
    if (flush) m_valid = 0;
    else if (adv && haz) m_valid = 0;
    else if (adv && ivalid) begin
      m_valid   = 1;
      m_pc      = pc;
      m_rs      = rs;
      m_rt      = rt;
      m_rs_data = rd_val(rs);
      m_rt_data = rd_val(rt);
      m_op      = op;
      m_funct   = instr % 64;
      m_shamt   = (instr >> 6) % 32;
      m_dest    = (op == 0) ? rd : (op == 3) ? 31 : rt;
      m_load    = (op >= 32 && op <= 39);
      if (op >= 12 && op <= 14) m_imm = im;
      else if (op == 15)        m_imm = im * 65536;
      else                      m_imm = (im >= 32768) ? im + 32'hFFFF_0000 : im;
    end else if (adv) m_valid = 0;
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  // Called at a falling edge with inputs already driven; compares, then advances one cycle.
  task automatic tick();
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("if_ready", 32'(if_ready), 32'(exp_ready_f()));
    if (m_valid) begin
      check("out_pc", out_pc, m_pc);
      check("out_rs_data", out_rs_data, m_rs_data);
      check("out_rt_data", out_rt_data, m_rt_data);
      check("out_imm", out_imm, m_imm);
      check("out_rs", 32'(out_rs), m_rs);
      check("out_rt", 32'(out_rt), m_rt);
      check("out_dest", 32'(out_dest), m_dest);
      check("out_opcode", 32'(out_opcode), m_op);
      check("out_funct", 32'(out_funct), m_funct);
      check("out_shamt", 32'(out_shamt), m_shamt);
      check("out_is_load", 32'(out_is_load), 32'(m_load));
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [31:0] i, input logic [31:0] p);
    instr = i; pc = p; ivalid = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int unsigned ops [12] = '{0, 0, 3, 8, 12, 13, 14, 15, 35, 32, 43, 4};
    logic [31:0] r;
    r = $urandom;
    r[31:26] = 6'(ops[$urandom_range(0, 11)]);
    r[25:21] = 5'($urandom_range(0, 7));
    r[20:16] = 5'($urandom_range(0, 7));
    r[15:11] = 5'($urandom_range(0, 7));
    return r;
  endfunction

  initial begin
    foreach (m_regs[i]) m_regs[i] = 0;
    m_valid = 0; m_load = 0; m_pc = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dest = 0; m_op = 0; m_funct = 0; m_shamt = 0;
    rst_n = 1'b0; instr = '0; pc = '0; ivalid = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset held for two cycles
    #1;
    check("reset_fields_zero", out_pc | out_rs_data | out_rt_data | out_imm |
          32'(out_rs) | 32'(out_rt) | 32'(out_dest) | 32'(out_opcode) | 32'(out_funct) |
          32'(out_shamt) | 32'(out_is_load), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 check("ready_after_reset", 32'(if_ready), 32'h1);
    present(32'h00A0_0820, 32'h0000_0040);  // ADD $1,$5,$0
    tick();
    ivalid = 1'b0;
    check("rs5_after_reset", out_rs_data, 32'h0);

    // Write-back then decode
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'h0000_1234;
    tick();
    wb_en = 1'b0;
    present(32'h0100_1820, 32'h0000_0044);  // ADD $3,$8,$0
    tick();
    ivalid = 1'b0;
    check("wb_valid", 32'(out_valid), 32'h1);
    check("wb_rs_data", out_rs_data, 32'h0000_1234);
    check("wb_dest", 32'(out_dest), 32'd3);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    tick();
    wb_en = 1'b0;
    present(32'h0000_1820, 32'h0000_0048);  // ADD $3,$0,$0
    tick();
    check("r0_stays_zero", out_rs_data, 32'h0);

    // Immediate extension
    present(32'h2001_FFFF, 32'h0000_004C);  // ADDI
    tick();
    check("imm_addi", out_imm, 32'hFFFF_FFFF);
    present(32'h3401_FFFF, 32'h0000_0050);  // ORI
    tick();
    check("imm_ori", out_imm, 32'h0000_FFFF);
    present(32'h3C01_ABCD, 32'h0000_0054);  // LUI
    tick();
    check("imm_lui", out_imm, 32'hABCD_0000);

    // Load-use hazard
    present(32'h8C29_0000, 32'h0000_0058);  // LW $9,0($1)
    tick();
    present(32'h0129_1020, 32'h0000_005C);  // ADD $2,$9,$9
    #1 check("hazard_ready", 32'(if_ready), 32'h0);
    tick();
    check("hazard_bubble", 32'(out_valid), 32'h0);
    tick();
    check("hazard_add_valid", 32'(out_valid), 32'h1);
    check("hazard_add_dest", 32'(out_dest), 32'd2);
    present(32'h8C20_0000, 32'h0000_0060);  // LW $0,0($1)
    tick();
    present(32'h0000_1020, 32'h0000_0064);  // ADD $2,$0,$0
    #1 check("lw_r0_no_stall", 32'(if_ready), 32'h1);
    tick();
    check("lw_r0_add_valid", 32'(out_valid), 32'h1);

    // Backpressure and flush
    present(32'h2005_0055, 32'h0000_0100);
    tick();
    ex_ready = 1'b0;
    present(32'h2006_0066, 32'h0000_0104);
    for (int k = 0; k < 3; k++) begin
      #1 check("stall_ready", 32'(if_ready), 32'h0);
      tick();
      check("stall_pc_held", out_pc, 32'h0000_0100);
    end
    flush = 1'b1;
    present(32'h2007_0077, 32'h0000_0200);
    tick();
    flush = 1'b0; ivalid = 1'b0; ex_ready = 1'b1;
    check("flush_valid", 32'(out_valid), 32'h0);
    tick();
    check("flushed_never_seen", 32'(out_valid), 32'h0);

    // Same-cycle write-back versus read
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h1111_1111;
    tick();
    wb_data = 32'hDEAD_BEEF;
    present(32'h0080_0820, 32'h0000_0300);  // ADD $1,$4,$0
    tick();
    wb_en = 1'b0; ivalid = 1'b0;
`ifdef WB_BYPASS_EN
    check("bypass_rs", out_rs_data, 32'hDEAD_BEEF);
`else
    check("no_bypass_rs", out_rs_data, 32'h1111_1111);
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      ivalid   = ($urandom_range(0, 3) != 0);
      instr    = rand_instr();
      pc       = $urandom;
      wb_en    = $urandom_range(0, 1) == 1;
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised MIPS instruction-decode pipeline stage.
- Contains a REG_COUNT-entry register file with a write-back port, immediate extension by opcode class, destination-register selection and load-use hazard detection.
- Holds a registered ID/EX output with a valid/ready handshake towards EX and a flush input.
- Sits between the fetch stage and the execute stage of the CPU pipeline.

Parameters:
- DATA_WIDTH, 32: register/data width in bits; must be >= 32.
- REG_COUNT, 32: number of architectural registers; register 0 is hardwired to zero.
- REG_ADDR_W, 5: register address width; REG_COUNT <= 2**REG_ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- if_instr  in  32  instruction from fetch.
- if_pc  in  32  PC of if_instr.
- if_valid  in  1  if_instr/if_pc are valid.
- if_ready  out  1  stage accepts if_instr this cycle.
- flush  in  1  kill the instruction being decoded (branch/jump taken).
- wb_en  in  1  write-back enable.
- wb_addr  in  REG_ADDR_W  write-back register index.
- wb_data  in  DATA_WIDTH  write-back data.
- ex_ready  in  1  EX consumes the ID/EX register this cycle.
- out_valid  out  1  ID/EX register holds a real instruction.
- out_pc  out  32  registered PC.
- out_rs_data  out  DATA_WIDTH  registered rs operand.
- out_rt_data  out  DATA_WIDTH  registered rt operand.
- out_imm  out  DATA_WIDTH  registered extended immediate.
- out_rs  out  REG_ADDR_W  registered rs index.
- out_rt  out  REG_ADDR_W  registered rt index.
- out_dest  out  REG_ADDR_W  registered destination index.
- out_opcode  out  6  registered opcode.
- out_funct  out  6  registered funct.
- out_shamt  out  5  registered shamt.
- out_is_load  out  1  registered instruction is a load.

Behaviour:
- Reset (rst=0 at a rising edge):
  - All registers clear to 0.
  - All out_* outputs clear to 0, including out_valid=0.
  - if_ready is 0 during the reset cycle.
- Field decode:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0], imm = [15:0].
  - Indices are truncated/zero-padded to REG_ADDR_W.
- Immediate extension:
  - Opcodes 0x0C, 0x0D, 0x0E (ANDI/ORI/XORI): zero-extend.
  - Opcode 0x0F (LUI): imm << 16, zero-filled.
  - All other opcodes: sign-extend to DATA_WIDTH.
- Destination select:
  - opcode 0x00: rd.
  - opcode 0x03 (JAL): 31.
  - Otherwise: rt.
- Load class: is_load = (opcode[5:3] == 3'b100).
- Register file:
  - Combinational reads of rs and rt; register 0 always reads 0.
  - Write at the rising edge when wb_en=1, wb_addr != 0 and wb_addr < REG_COUNT.
  - Writes to address 0 or an out-of-range address are ignored.
  - Writes happen regardless of stall or flush.
- Advance condition: adv = !out_valid || ex_ready.
- Hazard condition: hazard = out_valid && out_is_load && out_dest != 0 && (out_dest == rs || out_dest == rt) of if_instr.
  - Comparison is conservative: both fields are always compared.
- Ready: if_ready = rst && adv && !hazard.
- Next-state priority for the ID/EX register, highest first:
  1. Reset.
  2. flush=1: out_valid <= 0 at the next edge regardless of ex_ready; the instruction presented this cycle is consumed and discarded.
  3. adv && hazard: insert a bubble (out_valid <= 0); if_instr is not accepted, and fetch re-presents it.
  4. adv && if_valid: load all out_* fields from the decode; out_valid <= 1.
  5. adv && !if_valid: out_valid <= 0.
  6. !adv: hold all out_* unchanged.
- Latency: one cycle from acceptance to out_valid.
- Throughput: one instruction per cycle with no hazard.
- Load-use penalty: exactly one bubble cycle.
- out_* data fields may be don't-care while out_valid=0, but must not change while !adv.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: when wb_en=1 and wb_addr != 0 equals the rs (or rt) index, that read returns wb_data in the same cycle (write-before-read).
- Undefined: reads return the pre-write array value; the new value is visible from the next cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 2 cycles, then release.
  - Required: out_valid=0 and all out_*=0 during reset; if_ready=1 on the first cycle after release with ex_ready=1.
  - Then read rs=5: out_rs_data=0.
- Write-back then decode:
  - Stimulus: wb_en=1, wb_addr=8, wb_data=0x0000_1234, then next cycle ADD $3,$8,$0 (0x01001820).
  - Required: after 1 cycle out_valid=1, out_rs_data=0x1234, out_dest=3.
  - Writing wb_addr=0 leaves $0 reading 0.
- Immediate extension:
  - Stimulus: ADDI imm 0xFFFF, ORI imm 0xFFFF, LUI imm 0xABCD.
  - Required: out_imm = 0xFFFF_FFFF, 0x0000_FFFF, 0xABCD_0000 respectively.
- Load-use hazard:
  - Stimulus: LW $9,0($1) followed by ADD $2,$9,$9.
  - Required: cycle after LW enters ID/EX: if_ready=0 and a bubble is inserted (out_valid=0 for 1 cycle); ADD then appears with out_valid=1.
  - Same sequence with LW to $0: no stall.
- Backpressure and flush:
  - Stimulus: ex_ready=0 for 3 cycles.
  - Required: out_* stable and if_ready=0 throughout.
  - Stimulus: flush=1 with ex_ready=0.
  - Required: out_valid=0 next cycle, and the presented instruction never appears.
- Bypass, same cycle:
  - Stimulus: wb_en=1, wb_addr=4, wb_data=0xDEAD_BEEF while decoding rs=4.
  - Required: with WB_BYPASS_EN, out_rs_data=0xDEADBEEF; without it, out_rs_data equals the old $4 value.
